seven_seg_encoder: RTL and testbench
====================================

Name: seven_seg_encoder

Overview:
Display encoder for the two-mode timer. It takes two 8-bit binary counts (MSB pair and LSB pair) and converts each to two decimal digits. It then drives four active-low 7-segment patterns, forming a "MM.LL" four-digit display. Outputs are registered on the system clock and feed the board HEX displays directly.

Parameters:
BLANK_LEAD, 1, when 1 the MSB leading-zero blanking in mode 1 is enabled; when 0 mode 1 renders the same as mode 0.

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
LSBBinary  input  8  binary value for the right digit pair (HexLSBH/HexLSBL)
MSBBinary  input  8  binary value for the left digit pair (HexMSBH/HexMSBL)
ModeSel  input  1  0 = full display, 1 = leading-zero-blanked MSB display
HexMSBH  output  7  tens digit of MSBBinary, active-low segments
HexMSBL  output  7  units digit of MSBBinary
HexLSBH  output  7  tens digit of LSBBinary
HexLSBL  output  7  units digit of LSBBinary

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Segment format:
  - Bit order {g,f,e,d,c,b,a}; a 0 lights a segment.
  - Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank=1111111; dash=0111111.
- Conversion: each byte is split into tens = value/10 and units = value%10, both 0..9. Implement with combinational double-dabble or a compare-subtract chain; no multi-cycle divider.
- Range rule: a byte value >99 drives both of its digits to dash. This is evaluated independently per pair, and takes precedence over blanking.
- ModeSel=0: all four digits are always shown, including leading zeros (MSB=3, LSB=12 -> "03.12").
- ModeSel=1 (with BLANK_LEAD=1):
  - HexMSBH is blank when MSBBinary<10.
  - HexMSBL, HexLSBH and HexLSBL are unchanged from mode 0.
  - The LSB pair is never blanked.
- Timing:
  - All four outputs are registered.
  - Inputs sampled at a rising edge of Clock appear on the outputs after that edge: 1-cycle latency, no handshake.
  - Every edge loads a new value; there is no hold or enable.
- Reset:
  - Asserting Reset forces all four outputs to blank (1111111) immediately, without waiting for a clock edge.
  - The outputs stay blank while Reset is high.
  - The first rising edge after deassertion loads the encoded inputs.
- ModeSel and data changes in the same cycle are handled together; the next edge reflects both.
- No internal state besides the output registers.

Test Plan:
- Reset: assert Reset mid-run with MSB=67, LSB=45 -> all outputs 1111111 asynchronously. After release and one edge, outputs are 0000010, 1111000, 0011001, 0010010 ("67.45").
- Mode 0 with leading zero: ModeSel=0, MSB=3, LSB=12 -> after one edge, HexMSBH=1000000, HexMSBL=0110000, HexLSBH=1111001, HexLSBL=0100100 ("03.12").
- Mode 1 blanking: ModeSel=1, MSB=3, LSB=12 -> HexMSBH=1111111, other three digits unchanged from mode 0.
- Boundaries, both modes:
  - MSB=99, LSB=0 -> "99.00", with HexMSBH=0010000 in both modes.
  - MSB=10 in mode 1 -> HexMSBH=1111001 (not blanked).
  - MSB=9 in mode 1 -> HexMSBH blank.
- Out of range:
  - MSB=100, LSB=255 -> all four outputs 0111111 in both modes.
  - MSB=100, LSB=5 -> MSB pair dashes, LSB pair "05".
- Latency: change inputs between edges -> outputs change only at the next rising edge; exhaustive sweep 0..99 on each byte matches value/10 and value%10.

Source files
------------

// File: rtl/seven_seg_encoder_if.sv
// ---------------------------------------------------------------------------
// seven_seg_encoder_if
// Groups the two binary counts, the display mode and the four HEX digit
// patterns of the "MM.LL" timer display. The master supplies counts and mode;
// the slave (the encoder) returns active-low 7-segment patterns.
// ---------------------------------------------------------------------------
interface seven_seg_encoder_if;
  logic [7:0] LSBBinary;
  logic [7:0] MSBBinary;
  logic       ModeSel;
  logic [6:0] HexMSBH;
  logic [6:0] HexMSBL;
  logic [6:0] HexLSBH;
  logic [6:0] HexLSBL;

  modport master (
    output LSBBinary,
    output MSBBinary,
    output ModeSel,
    input  HexMSBH,
    input  HexMSBL,
    input  HexLSBH,
    input  HexLSBL
  );

  modport slave (
    input  LSBBinary,
    input  MSBBinary,
    input  ModeSel,
    output HexMSBH,
    output HexMSBL,
    output HexLSBH,
    output HexLSBL
  );
endinterface : seven_seg_encoder_if

// File: rtl/seven_seg_encoder.sv
// ---------------------------------------------------------------------------
// seven_seg_encoder
// Converts two 8-bit binary counts into four active-low 7-segment digits
// ("MM.LL"). Each byte is split into tens/units with a combinational
// compare-subtract chain. Values above 99 show as two dashes for that pair.
// In mode 1 the MSB tens digit is blanked when the MSB count is below 10
// (only when BLANK_LEAD is set). All outputs are registered with a single
// cycle of latency. Reset blanks the display asynchronously.
// ---------------------------------------------------------------------------
module seven_seg_encoder #(
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  seven_seg_encoder_if.slave  bus
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [7:0] MAX_SHOWN = 8'd99;

  // Decimal digit to active-low {g,f,e,d,c,b,a} pattern; non-digits go blank.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Tens digit by comparing against each multiple of ten. Only meaningful
  // for 0..99; larger values are replaced by dashes before display.
  function automatic logic [3:0] f_tens(input logic [7:0] v);
    logic [3:0] t;
    if      (v >= 8'd90) t = 4'd9;
    else if (v >= 8'd80) t = 4'd8;
    else if (v >= 8'd70) t = 4'd7;
    else if (v >= 8'd60) t = 4'd6;
    else if (v >= 8'd50) t = 4'd5;
    else if (v >= 8'd40) t = 4'd4;
    else if (v >= 8'd30) t = 4'd3;
    else if (v >= 8'd20) t = 4'd2;
    else if (v >= 8'd10) t = 4'd1;
    else                 t = 4'd0;
    return t;
  endfunction

  // Units digit: subtract the already-found tens multiple.
  function automatic logic [3:0] f_units(input logic [7:0] v, input logic [3:0] t);
    logic [7:0] rem;
    rem = v - ({4'd0, t} * 8'd10);
    return rem[3:0];
  endfunction

  logic [3:0] w_msb_tens;
  logic [3:0] w_msb_units;
  logic [3:0] w_lsb_tens;
  logic [3:0] w_lsb_units;
  logic [6:0] w_msb_h;
  logic [6:0] w_msb_l;
  logic [6:0] w_lsb_h;
  logic [6:0] w_lsb_l;

  logic [6:0] r_msb_h;
  logic [6:0] r_msb_l;
  logic [6:0] r_lsb_h;
  logic [6:0] r_lsb_l;

  // Next display patterns: range check first, then leading-zero blanking.
  always_comb begin
    w_msb_tens  = f_tens(bus.MSBBinary);
    w_msb_units = f_units(bus.MSBBinary, w_msb_tens);
    w_lsb_tens  = f_tens(bus.LSBBinary);
    w_lsb_units = f_units(bus.LSBBinary, w_lsb_tens);
    w_msb_h     = SEG_BLANK;
    w_msb_l     = SEG_BLANK;
    w_lsb_h     = SEG_BLANK;
    w_lsb_l     = SEG_BLANK;

    if (bus.MSBBinary > MAX_SHOWN) begin
      w_msb_h = SEG_DASH;
      w_msb_l = SEG_DASH;
    end else begin
      w_msb_l = f_seg(w_msb_units);
      if (BLANK_LEAD && bus.ModeSel && (bus.MSBBinary < 8'd10)) begin
        w_msb_h = SEG_BLANK;
      end else begin
        w_msb_h = f_seg(w_msb_tens);
      end
    end

    // The LSB pair is never blanked, only dashed when out of range.
    if (bus.LSBBinary > MAX_SHOWN) begin
      w_lsb_h = SEG_DASH;
      w_lsb_l = SEG_DASH;
    end else begin
      w_lsb_h = f_seg(w_lsb_tens);
      w_lsb_l = f_seg(w_lsb_units);
    end
  end

  // Output registers: blank on reset, otherwise load every edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_msb_h <= SEG_BLANK;
      r_msb_l <= SEG_BLANK;
      r_lsb_h <= SEG_BLANK;
      r_lsb_l <= SEG_BLANK;
    end else begin
      r_msb_h <= w_msb_h;
      r_msb_l <= w_msb_l;
      r_lsb_h <= w_lsb_h;
      r_lsb_l <= w_lsb_l;
    end
  end

  assign bus.HexMSBH = r_msb_h;
  assign bus.HexMSBL = r_msb_l;
  assign bus.HexLSBH = r_lsb_h;
  assign bus.HexLSBL = r_lsb_l;

endmodule : seven_seg_encoder

// File: tb/tb_seven_seg_encoder.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_encoder
// Directed bench for the seven-segment encoder: reset, both display modes,
// boundaries, out-of-range dashes, latency and a 0..99 sweep.
// ---------------------------------------------------------------------------
module tb_seven_seg_encoder;

  localparam logic [6:0] BLK  = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [6:0] lut [0:9];

  seven_seg_encoder_if u_if ();

  seven_seg_encoder #(.BLANK_LEAD(1'b1)) u_dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (u_if.slave)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive new inputs away from the edge, then sample just after the next edge.
  task automatic apply(input logic [7:0] msb, input logic [7:0] lsb, input logic mode);
    @(negedge clk);
    u_if.MSBBinary = msb;
    u_if.LSBBinary = lsb;
    u_if.ModeSel   = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [6:0] mh, input logic [6:0] ml,
                        input logic [6:0] lh, input logic [6:0] ll);
    check_eq({tag, ".MSBH"}, u_if.HexMSBH, mh);
    check_eq({tag, ".MSBL"}, u_if.HexMSBL, ml);
    check_eq({tag, ".LSBH"}, u_if.HexLSBH, lh);
    check_eq({tag, ".LSBL"}, u_if.HexLSBL, ll);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    lut[0] = 7'b1000000; lut[1] = 7'b1111001; lut[2] = 7'b0100100;
    lut[3] = 7'b0110000; lut[4] = 7'b0011001; lut[5] = 7'b0010010;
    lut[6] = 7'b0000010; lut[7] = 7'b1111000; lut[8] = 7'b0000000;
    lut[9] = 7'b0010000;

    rst = 1'b1;
    u_if.MSBBinary = 8'd0;
    u_if.LSBBinary = 8'd0;
    u_if.ModeSel   = 1'b0;
    #2;
    check4("reset_init", BLK, BLK, BLK, BLK);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0 keeps the leading zero: "03.12".
    apply(8'd3, 8'd12, 1'b0);
    check4("mode0_03_12", 7'b1000000, 7'b0110000, 7'b1111001, 7'b0100100);

    // Mode 1 blanks only the MSB tens digit.
    apply(8'd3, 8'd12, 1'b1);
    check4("mode1_03_12", BLK, 7'b0110000, 7'b1111001, 7'b0100100);

    // Reset mid-run blanks asynchronously and holds while asserted.
    apply(8'd67, 8'd45, 1'b0);
    check4("pre_reset_67_45", 7'b0000010, 7'b1111000, 7'b0011001, 7'b0010010);
    #2;
    rst = 1'b1;
    #1;
    check4("async_reset", BLK, BLK, BLK, BLK);
    @(posedge clk);
    #1;
    check4("reset_held", BLK, BLK, BLK, BLK);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check4("post_reset_67_45", 7'b0000010, 7'b1111000, 7'b0011001, 7'b0010010);

    // Boundaries in both modes.
    apply(8'd99, 8'd0, 1'b0);
    check4("mode0_99_00", 7'b0010000, 7'b0010000, 7'b1000000, 7'b1000000);
    apply(8'd99, 8'd0, 1'b1);
    check4("mode1_99_00", 7'b0010000, 7'b0010000, 7'b1000000, 7'b1000000);
    apply(8'd10, 8'd7, 1'b1);
    check4("mode1_10_07", 7'b1111001, 7'b1000000, 7'b1000000, 7'b1111000);
    apply(8'd9, 8'd0, 1'b1);
    check4("mode1_09_00", BLK, 7'b0010000, 7'b1000000, 7'b1000000);
    apply(8'd0, 8'd0, 1'b1);
    check4("mode1_00_00", BLK, 7'b1000000, 7'b1000000, 7'b1000000);

    // Out of range: dashes win over blanking, independent per pair.
    apply(8'd100, 8'd255, 1'b0);
    check4("mode0_100_255", DASH, DASH, DASH, DASH);
    apply(8'd100, 8'd255, 1'b1);
    check4("mode1_100_255", DASH, DASH, DASH, DASH);
    apply(8'd100, 8'd5, 1'b1);
    check4("mode1_100_05", DASH, DASH, 7'b1000000, 7'b0010010);
    apply(8'd42, 8'd100, 1'b0);
    check4("mode0_42_100", 7'b0011001, 7'b0100100, DASH, DASH);

    // Latency: a mid-cycle input change is invisible until the next edge.
    apply(8'd58, 8'd31, 1'b0);
    check4("lat_before", 7'b0010010, 7'b0000000, 7'b0110000, 7'b1111001);
    u_if.MSBBinary = 8'd4;
    u_if.LSBBinary = 8'd76;
    u_if.ModeSel   = 1'b1;
    @(negedge clk);
    check4("lat_hold", 7'b0010010, 7'b0000000, 7'b0110000, 7'b1111001);
    @(posedge clk);
    #1;
    check4("lat_after", BLK, 7'b0011001, 7'b1111000, 7'b0000010);

    // Sweep 0..99 on both bytes (LSB runs in reverse) against value/10, value%10.
    for (int v = 0; v < 100; v++) begin
      int w;
      w = 99 - v;
      apply(8'(v), 8'(w), 1'b0);
      check4($sformatf("sweep_%0d_%0d", v, w),
             lut[v / 10], lut[v % 10], lut[w / 10], lut[w % 10]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seven_seg_encoder
